// File: rtl/seq_array_multiplier.sv
// Iterative shift-add multiplier: one radix-2 partial product per clock, valid/ready on both sides.
// Define MULT_SIGNED_EN to add the sgn port and two's-complement operand handling.
module seq_array_multiplier #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
`ifdef MULT_SIGNED_EN
  ,
  input  logic               sgn
`endif
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    p_q, p_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             neg_q, neg_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic             neg_in;
  logic [PW-1:0]    sum;

  // Operand conditioning at accept: magnitudes plus the sign of the product
`ifdef MULT_SIGNED_EN
  always_comb begin
    a_mag  = (sgn && a[WIDTH-1]) ? (~a) + WIDTH'(1) : a;
    b_mag  = (sgn && b[WIDTH-1]) ? (~b) + WIDTH'(1) : b;
    neg_in = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
  end
`else
  always_comb begin
    a_mag  = a;
    b_mag  = b;
    neg_in = 1'b0;
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    p_d      = p_q;
    neg_d    = neg_q;
    sum      = acc_q + (mcand_q[0] ? (PW'(mplier_q) << cnt_q) : '0);

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = neg_in;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d   = sum;
        mcand_d = mcand_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        // Last partial product: publish the (possibly negated) result
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          p_d     = neg_q ? (~sum) + PW'(1) : sum;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      p_q         <= '0;
      neg_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      p_q         <= p_d;
      neg_q       <= neg_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign p         = p_q;

endmodule
